// File: rtl/imem_fetch.sv
// ---------------------------------------------------------------------------
// imem_fetch
//
// Instruction-fetch initiator for a synchronous-read instruction memory.
// Keeps the fetch PC, issues one aligned word read per cycle, absorbs the
// one-cycle imem read latency in a 2-entry buffer and presents decode with a
// valid/ready instruction stream. Supports redirect (flush + restart) and
// reports fetches from illegal addresses as fault entries, after which fetch
// halts until the next redirect.
//
// Ports:
//   clk              rising-edge clock, shared with imem
//   rst_n            asynchronous active-low reset
//   imem_addr        byte address presented to imem (the pc_req register)
//   imem_write_en    tied 0, fetch never writes
//   imem_write_data  tied 0
//   imem_read_data   imem data, valid the cycle after the address is sampled
//   redirect_valid   one-cycle request to restart fetch at redirect_pc
//   redirect_pc      new fetch address
//   instr_valid      buffer head valid
//   instr_ready      decode accepts the head when instr_valid && instr_ready
//   instr            instruction word at the buffer head
//   instr_pc         byte address of instr
//   instr_fault      head entry came from an illegal address
// ---------------------------------------------------------------------------
module imem_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_write_en,
    output logic [31:0] imem_write_data,
    input  logic [31:0] imem_read_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault
);

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_req_reg;
    logic [31:0] req_pc_reg;
    logic        inflight_reg;

    // 2-entry buffer storage and bookkeeping
    logic [31:0] buf_instr_reg [2];
    logic [31:0] buf_pc_reg    [2];
    logic        buf_fault_reg [2];
    logic        head_reg;
    logic        tail_reg;
    logic [1:0]  count_reg;

    logic        pop;
    logic        push;
    logic        resp_fault;
    logic        fault_push;
    logic [2:0]  occupancy;
    logic        credit_ok;
    logic        issue;
    logic [1:0]  wr_en;

    assign pop        = (count_reg != 2'd0) && instr_ready;
    // The fault depends only on the requested address, never on the data.
    assign resp_fault = (req_pc_reg[1:0] != 2'b00) || (req_pc_reg > LAST_WORD);
    // A redirect discards the response that is in flight.
    assign push       = inflight_reg && !redirect_valid;
    assign fault_push = push && resp_fault;

    // Buffered entries plus the outstanding response, minus what leaves this
    // cycle, must leave room for one more response. count+inflight never
    // exceeds 2 and pop implies count>=1, so this cannot underflow.
    assign occupancy  = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign credit_ok  = occupancy < 3'd2;

    // A fault entry being written kills the request that would issue alongside
    // it, so pc_req stays at the address following the faulting one.
    assign issue = (state_reg == RUN) && !redirect_valid && credit_ok && !fault_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            pc_req_reg   <= RESET_PC;
            req_pc_reg   <= '0;
            inflight_reg <= 1'b0;
            head_reg     <= 1'b0;
            tail_reg     <= 1'b0;
            count_reg    <= 2'd0;
        end else if (redirect_valid) begin
            // Flush everything; a handshake in this cycle simply completes.
            state_reg    <= RUN;
            pc_req_reg   <= redirect_pc;
            inflight_reg <= 1'b0;
            head_reg     <= 1'b0;
            tail_reg     <= 1'b0;
            count_reg    <= 2'd0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                req_pc_reg <= pc_req_reg;
                pc_req_reg <= pc_req_reg + 32'd4;
            end
            if (fault_push) begin
                state_reg <= HALT;
            end
            if (push) begin
                tail_reg <= ~tail_reg;
            end
            if (pop) begin
                head_reg <= ~head_reg;
            end
            count_reg <= count_reg + 2'(push) - 2'(pop);
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            assign wr_en[gi] = push && (tail_reg == 1'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    buf_instr_reg[gi] <= '0;
                    buf_pc_reg[gi]    <= '0;
                    buf_fault_reg[gi] <= 1'b0;
                end else if (wr_en[gi]) begin
                    buf_instr_reg[gi] <= resp_fault ? 32'hFFFF_FFFF : imem_read_data;
                    buf_pc_reg[gi]    <= req_pc_reg;
                    buf_fault_reg[gi] <= resp_fault;
                end
            end
        end
    endgenerate

    assign imem_addr       = pc_req_reg;
    assign imem_write_en   = 1'b0;
    assign imem_write_data = '0;

    assign instr_valid = (count_reg != 2'd0);
    assign instr       = buf_instr_reg[head_reg];
    assign instr_pc    = buf_pc_reg[head_reg];
    assign instr_fault = buf_fault_reg[head_reg];

endmodule

// File: tb/tb_imem_fetch.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch
//
// Self-checking bench for imem_fetch with a 64-byte imem. Expected stream
// entries are pushed to a scoreboard queue when a redirect/reset starts a
// stream and popped on each completed handshake. A table of redirect targets
// covers end-of-memory, misaligned, wrap and out-of-range starts; hand-written
// sequences cover reset latency, backpressure, redirect latency and an
// asynchronous reset in the middle of a stream.
// ---------------------------------------------------------------------------
module tb_imem_fetch;

    localparam int          MEM_BYTES_TB = 64;
    localparam logic [31:0] LAST_WORD_TB = 32'(MEM_BYTES_TB - 4);

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_write_en;
    logic [31:0] imem_write_data;
    logic [31:0] imem_read_data = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;

    imem_fetch #(
        .RESET_PC  (32'h0000_0000),
        .MEM_BYTES (MEM_BYTES_TB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_write_en   (imem_write_en),
        .imem_write_data (imem_write_data),
        .imem_read_data  (imem_read_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_fault     (instr_fault)
    );

    always #5 clk = ~clk;

    // Word at 0x24 is all-ones to show that data alone never makes a fault.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h24) ? 32'hFFFF_FFFF : (32'hA500_0000 | a);
    endfunction

    // Synchronous-read imem model: one cycle of latency.
    always @(posedge clk) imem_read_data <= mem_word(imem_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [31:0] target;
        int          cycles;
        bit          rand_ready;
        logic [31:0] end_addr;
        int          n_expect;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.fault = (pc[1:0] != 2'b00) || (pc > LAST_WORD_TB);
        e.word  = e.fault ? 32'hFFFF_FFFF : mem_word(pc);
        return e;
    endfunction

    // Expected stream from 'target' up to and including the first fault.
    task automatic push_stream(input logic [31:0] target);
        logic [31:0] pc;
        exp_t        e;
        pc = target;
        for (int k = 0; k < 20; k++) begin
            e = model(pc);
            sb.push_back(e);
            if (e.fault) break;
            pc = pc + 32'd4;
        end
    endtask

    // Drive inputs for the next edge at the falling edge and score the
    // handshake that edge will complete. Outputs do not depend on inputs
    // combinationally, so they are already stable here.
    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
        exp_t e;
        @(negedge clk);
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rst_n && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected got pc=%h want no transfer", instr_pc);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", instr_pc, e.pc);
                chk("sb_instr", instr, e.word);
                chk("sb_fault", {31'b0, instr_fault}, {31'b0, e.fault});
                pops++;
                $display("xfer pc=%h instr=%h fault=%0d", instr_pc, instr, instr_fault);
            end
        end
        if (rv) begin
            sb.delete();
            pops = 0;
        end
    endtask

    initial begin
        vecs[0] = '{32'h0000_0038, 10, 1'b0, 32'h0000_0044, 3};
        vecs[1] = '{32'h0000_0006,  8, 1'b0, 32'h0000_000A, 1};
        vecs[2] = '{32'h0000_0000, 60, 1'b1, 32'h0000_0044, 17};
        vecs[3] = '{32'h0000_0020, 40, 1'b1, 32'h0000_0044, 9};
        vecs[4] = '{32'hFFFF_FFFC,  8, 1'b0, 32'h0000_0000, 1};
        vecs[5] = '{32'h0000_1000,  8, 1'b0, 32'h0000_1004, 1};
        vecs[6] = '{32'h0000_003D,  8, 1'b0, 32'h0000_0041, 1};

        rst_n          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_fault", {31'b0, instr_fault}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_we", {31'b0, imem_write_en}, 32'd0);
        chk("rst_wdata", imem_write_data, 32'd0);

        // ---- release: first valid after the 2nd edge ----
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        push_stream(32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("lat_edge1_valid", {31'b0, instr_valid}, 32'd0);
        chk("lat_edge1_addr", imem_addr, 32'h4);
        cycle(1'b1, 1'b0, 32'h0);
        chk("lat_edge2_valid", {31'b0, instr_valid}, 32'd1);
        chk("lat_edge2_pc", instr_pc, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("stream_valid", {31'b0, instr_valid}, 32'd1);

        // ---- backpressure from pc 0x8 ----
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            chk("bp_valid", {31'b0, instr_valid}, 32'd1);
            chk("bp_head_pc", instr_pc, 32'h8);
        end
        chk("bp_addr", imem_addr, 32'h10);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            chk("bp_release_valid", {31'b0, instr_valid}, 32'd1);
        end

        // ---- redirect with buffered entries: 2 edges to first valid ----
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h2C);
        push_stream(32'h2C);
        cycle(1'b1, 1'b0, 32'h0);
        chk("redir_e0_valid", {31'b0, instr_valid}, 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("redir_e1_valid", {31'b0, instr_valid}, 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("redir_e2_valid", {31'b0, instr_valid}, 32'd1);
        chk("redir_e2_pc", instr_pc, 32'h2C);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0);
        chk("redir_halt_valid", {31'b0, instr_valid}, 32'd0);
        chk("redir_halt_addr", imem_addr, 32'h44);
        chk("redir_drained", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
        chk("halt_hold_addr", imem_addr, 32'h44);
        chk("halt_hold_valid", {31'b0, instr_valid}, 32'd0);

        // ---- table of redirect targets ----
        for (int v = 0; v < 7; v++) begin
            cycle(1'b1, 1'b1, vecs[v].target);
            push_stream(vecs[v].target);
            for (int c = 0; c < vecs[v].cycles; c++) begin
                cycle(vecs[v].rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0, 32'h0);
            end
            for (int c = 0; c < 4; c++) cycle(1'b1, 1'b0, 32'h0);
            chk("vec_pops", 32'(pops), 32'(vecs[v].n_expect));
            chk("vec_drained", 32'(sb.size()), 32'd0);
            chk("vec_halt_valid", {31'b0, instr_valid}, 32'd0);
            chk("vec_end_addr", imem_addr, vecs[v].end_addr);
        end

        // ---- asynchronous reset with two entries buffered ----
        cycle(1'b0, 1'b1, 32'h0);
        push_stream(32'h0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
        chk("arst_pre_valid", {31'b0, instr_valid}, 32'd1);
        chk("arst_pre_addr", imem_addr, 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, instr_valid}, 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_pc", instr_pc, 32'h0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        pops  = 0;
        push_stream(32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("arst_lat1_valid", {31'b0, instr_valid}, 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("arst_lat2_valid", {31'b0, instr_valid}, 32'd1);
        chk("arst_lat2_pc", instr_pc, 32'h0);
        for (int i = 0; i < 25; i++) cycle(1'b1, 1'b0, 32'h0);
        chk("arst_pops", 32'(pops), 32'd17);
        chk("arst_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
